// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_add_slice.sv
// Combinational WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module mult_add_slice #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] S,
    output logic             C,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin
);

    logic [WIDTH:0] carry;

    assign carry[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign S[gi]       = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign C = carry[WIDTH];

endmodule

// File: rtl/mult_8x8_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one conditional add and right shift per cycle,
// operands and product exchanged over valid/ready handshakes.
module mult_8x8_shift_add
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;

    logic [WIDTH-1:0]     hi, lo, addend, sum;
    logic                 carry;

    assign hi = acc_q[2*WIDTH-1:WIDTH];
    assign lo = acc_q[WIDTH-1:0];

    // Adding zero when the multiplier bit is clear keeps the datapath a single add-then-shift.
    assign addend = lo[0] ? mcand_q : '0;

    mult_add_slice #(
        .WIDTH (WIDTH)
    ) u_add (
        .S   (sum),
        .C   (carry),
        .A   (hi),
        .B   (addend),
        .Cin (1'b0)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Carry lands in the MSB, so the final product never overflows.
                acc_d   = {carry, sum, lo[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign product   = acc_q;

endmodule

// File: tb/tb_mult_8x8_shift_add.sv
// Directed bench for the shift-and-add multiplier: reset, latency, corner products,
// output back-pressure, ignored inputs while busy and mid-operation reset.
module tb_mult_8x8_shift_add;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int total_checks;
    int passed_checks;

    mult_8x8_shift_add #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operand pair and waits (bounded) for out_valid; returns product and latency.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] p, output int lat, output bit timeout);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat     = 0;
        timeout = 1'b1;
        p       = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        p = product;
        $display("op %0d*%0d -> product=%0d latency=%0d timeout=%0d", av, bv, p, lat, timeout);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        a         = 8'd5;
        b         = 8'd6;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'd0)
            $display("FAIL reset_values: got in_ready=%b out_valid=%b busy=%b product=%h expected 1 0 0 0000",
                     in_ready, out_valid, busy, product);
        else passed_checks++;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        total_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_nothing_accepted: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
        else passed_checks++;
        $display("reset done");
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat;
        bit to;
        run_op(8'd13, 8'd11, p, lat, to);
        total_checks++;
        if (to || lat != 8) $display("FAIL basic_latency: got %0d (timeout=%0d) expected 8", lat, to);
        else passed_checks++;
        total_checks++;
        if (p !== 16'd143) $display("FAIL basic_product: got %0d expected 143", p);
        else passed_checks++;
        consume();
        total_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_return_idle: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        else passed_checks++;
    endtask

    task automatic test_boundary();
        logic [15:0] p;
        int lat;
        bit to;
        run_op(8'd255, 8'd255, p, lat, to);
        total_checks++;
        if (to || p !== 16'hFE01) $display("FAIL max_product: got %h expected fe01", p);
        else passed_checks++;
        consume();
        run_op(8'd0, 8'd200, p, lat, to);
        total_checks++;
        if (to || p !== 16'd0) $display("FAIL zero_product: got %h expected 0000", p);
        else passed_checks++;
        total_checks++;
        if (lat != 8) $display("FAIL zero_latency: got %0d expected 8", lat);
        else passed_checks++;
        consume();
    endtask

    task automatic test_hold();
        logic [15:0] p;
        int lat;
        bit to;
        bit ok;
        run_op(8'd100, 8'd3, p, lat, to);
        ok = !to;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || product !== 16'd300 || in_ready !== 1'b0) ok = 1'b0;
        end
        total_checks++;
        if (!ok)
            $display("FAIL hold_stable: got out_valid=%b product=%0d in_ready=%b expected 1 300 0",
                     out_valid, product, in_ready);
        else passed_checks++;
        consume();
        total_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        else passed_checks++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit to;
        @(negedge clk);
        a        = 8'd20;
        b        = 8'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        total_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL busy_flags: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
        else passed_checks++;
        repeat (2) @(posedge clk);
        #1;
        a        = 8'd7;
        b        = 8'd7;
        in_valid = 1'b1;
        lat      = 2;
        to       = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            #1 in_valid = 1'b0;
            if (out_valid) begin
                to = 1'b0;
                break;
            end
        end
        $display("op 20*5 with 7*7 pulsed while busy -> product=%0d latency=%0d", product, lat);
        total_checks++;
        if (to || product !== 16'd100 || lat != 8)
            $display("FAIL busy_ignore: got product=%0d latency=%0d expected 100 8", product, lat);
        else passed_checks++;
        consume();
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat;
        bit to;
        run_op(8'd3, 8'd4, p, lat, to);
        total_checks++;
        if (to || p !== 16'd12) $display("FAIL b2b_first: got %0d expected 12", p);
        else passed_checks++;
        consume();
        run_op(8'd9, 8'd9, p, lat, to);
        total_checks++;
        if (to || p !== 16'd81) $display("FAIL b2b_second: got %0d expected 81", p);
        else passed_checks++;
        consume();
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        bit to;
        @(negedge clk);
        a        = 8'd50;
        b        = 8'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'd0)
            $display("FAIL mid_reset: got in_ready=%b out_valid=%b busy=%b product=%h expected 1 0 0 0000",
                     in_ready, out_valid, busy, product);
        else passed_checks++;
        $display("async reset asserted mid-operation");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd2, 8'd3, p, lat, to);
        total_checks++;
        if (to || p !== 16'd6) $display("FAIL after_reset_op: got %0d expected 6", p);
        else passed_checks++;
        consume();
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
